// File: rtl/mdio_phy_slave.sv
// -----------------------------------------------------------------------------
// mdio_phy_slave
//
// Clause-22 style MDIO management slave (PHY side). The controller's MDC, MDIO
// data and drive-enable are brought into the clk domain through two-stage
// synchronizers. Frames are decoded bit by bit on detected MDC rises. Read data
// is driven back on the MDC falls. A 32 x 16 register file holds the
// management registers.
//
// Ports
//   clk        system clock, all state updates on its rising edge
//   RESET      asynchronous active-high reset
//   MDC        management clock from the controller (asynchronous to clk)
//   MDIO_OUT   serial frame bits from the controller
//   MDIO_OE    controller drive enable, 1 = MDIO_OUT is valid
//   MDIO_IN    serial read data returned to the controller, idles at 1
//   PHY_OE     1 while this block drives MDIO_IN
//   WR_STROBE  one-clk pulse after a completed register write
//   WR_ADDR    register address of the last write
//   WR_DATA    data of the last write
//   FRAME_ERR  one-clk pulse on a malformed frame
// -----------------------------------------------------------------------------
module mdio_phy_slave #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic        PHY_OE,
  output logic        WR_STROBE,
  output logic [4:0]  WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic        FRAME_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WR,
    ST_RD,
    ST_SKIP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // ---------------------------------------------------------------------------
  // Input synchronizers (two stages each)
  // ---------------------------------------------------------------------------
  logic mdc_s1_reg,  mdc_s2_reg;
  logic mdio_s1_reg, mdio_s2_reg;
  logic oe_s1_reg,   oe_s2_reg;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      mdc_s1_reg  <= 1'b0;
      mdc_s2_reg  <= 1'b0;
      mdio_s1_reg <= 1'b0;
      mdio_s2_reg <= 1'b0;
      oe_s1_reg   <= 1'b0;
      oe_s2_reg   <= 1'b0;
    end else begin
      mdc_s1_reg  <= MDC;
      mdc_s2_reg  <= mdc_s1_reg;
      mdio_s1_reg <= MDIO_OUT;
      mdio_s2_reg <= mdio_s1_reg;
      oe_s1_reg   <= MDIO_OE;
      oe_s2_reg   <= oe_s1_reg;
    end
  end

  // Edges are seen one stage apart; the bit itself is taken from stage 1 so it
  // is aligned with the newer MDC sample.
  logic mdc_rise;
  logic mdc_fall;
  logic bit_in;
  logic oe_in;

  assign mdc_rise = mdc_s1_reg & ~mdc_s2_reg;
  assign mdc_fall = ~mdc_s1_reg & mdc_s2_reg;
  assign bit_in   = mdio_s1_reg;
  assign oe_in    = oe_s1_reg;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  logic [5:0]  bit_cnt_reg;   // index of the next MDC rise within the frame
  logic [10:0] hdr_reg;       // header bits, newest in bit 0
  logic [4:0]  regad_reg;     // register address captured at bit 13
  logic [14:0] data_reg;      // write data collected so far
  logic [15:0] rd_shift_reg;  // read data, MSB shifted out first

  logic [15:0] regs [32];

  // At the bit-13 rise the complete OP/PHYAD/REGAD field is the stored header
  // plus the bit currently being sampled. Bit 1 has already been shifted out
  // of hdr_reg by then, which is fine because it was checked on its own rise.
  logic [11:0] frame_hdr;
  logic [1:0]  frame_op;
  logic [4:0]  frame_phyad;
  logic [4:0]  frame_regad;
  logic        phy_match;

  assign frame_hdr   = {hdr_reg, bit_in};
  assign frame_op    = frame_hdr[11:10];
  assign frame_phyad = frame_hdr[9:5];
  assign frame_regad = frame_hdr[4:0];
  assign phy_match   = (frame_phyad == PHY_ADDR);

  // A write commits on the bit-31 rise, provided the controller still drives.
  logic        wr_fire;
  logic [15:0] wr_word;

  assign wr_fire = (state_reg == ST_WR) && mdc_rise && oe_in && (bit_cnt_reg == 6'd31);
  assign wr_word = {data_reg, bit_in};

  // ---------------------------------------------------------------------------
  // Register file. It is cleared by reset, so it is built from flops rather
  // than a RAM macro.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (wr_fire) begin
      regs[regad_reg] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= 6'd0;
      hdr_reg      <= 11'd0;
      regad_reg    <= 5'd0;
      data_reg     <= 15'd0;
      rd_shift_reg <= 16'd0;
      MDIO_IN      <= 1'b1;
      PHY_OE       <= 1'b0;
      WR_STROBE    <= 1'b0;
      WR_ADDR      <= 5'd0;
      WR_DATA      <= 16'd0;
      FRAME_ERR    <= 1'b0;
    end else begin
      // Both strobes are single-cycle; they are raised below only when needed.
      WR_STROBE <= 1'b0;
      FRAME_ERR <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          MDIO_IN     <= 1'b1;
          PHY_OE      <= 1'b0;
          bit_cnt_reg <= 6'd0;
          // Preamble ones (and undriven rises) are ignored; the first driven
          // zero is ST bit 0.
          if (mdc_rise && oe_in && !bit_in) begin
            bit_cnt_reg <= 6'd1;
            state_reg   <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (mdc_rise) begin
            if ((bit_cnt_reg == 6'd1) && !bit_in) begin
              // ST must be 01
              FRAME_ERR   <= 1'b1;
              bit_cnt_reg <= 6'd0;
              state_reg   <= ST_IDLE;
            end else if (bit_cnt_reg == 6'd13) begin
              bit_cnt_reg <= 6'd14;
              regad_reg   <= frame_regad;
              if ((frame_op == OP_WRITE) && phy_match) begin
                state_reg <= ST_WR;
              end else if ((frame_op == OP_READ) && phy_match) begin
                rd_shift_reg <= regs[frame_regad];
                state_reg    <= ST_RD;
              end else begin
                // Illegal opcodes are reported even when addressed elsewhere;
                // a plain address mismatch is silently skipped.
                if ((frame_op != OP_WRITE) && (frame_op != OP_READ)) begin
                  FRAME_ERR <= 1'b1;
                end
                state_reg <= ST_SKIP;
              end
            end else begin
              hdr_reg     <= {hdr_reg[9:0], bit_in};
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
          end
        end

        ST_WR: begin
          if (mdc_rise) begin
            if (!oe_in) begin
              // Controller let go of the line mid-frame: abandon the write.
              FRAME_ERR   <= 1'b1;
              bit_cnt_reg <= 6'd0;
              state_reg   <= ST_IDLE;
            end else if (bit_cnt_reg == 6'd31) begin
              WR_ADDR     <= regad_reg;
              WR_DATA     <= wr_word;
              WR_STROBE   <= 1'b1;
              bit_cnt_reg <= 6'd0;
              state_reg   <= ST_IDLE;
            end else begin
              // TA bits shift through too; they fall off the top by bit 31.
              data_reg    <= {data_reg[13:0], bit_in};
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
          end
        end

        ST_RD: begin
          // Rises only advance the counter; controller bits are ignored here.
          if (mdc_rise && (bit_cnt_reg != 6'd32)) begin
            bit_cnt_reg <= bit_cnt_reg + 6'd1;
          end
          // Drive on falls so the controller sees a stable bit at its next rise.
          // bit_cnt_reg is one past the most recent rise.
          if (mdc_fall) begin
            if (bit_cnt_reg == 6'd15) begin
              PHY_OE  <= 1'b1;
              MDIO_IN <= 1'b0;          // second turnaround bit
            end else if ((bit_cnt_reg >= 6'd16) && (bit_cnt_reg <= 6'd31)) begin
              MDIO_IN      <= rd_shift_reg[15];
              rd_shift_reg <= {rd_shift_reg[14:0], 1'b0};
            end else if (bit_cnt_reg == 6'd32) begin
              PHY_OE      <= 1'b0;
              MDIO_IN     <= 1'b1;
              bit_cnt_reg <= 6'd0;
              state_reg   <= ST_IDLE;
            end
          end
        end

        ST_SKIP: begin
          if (mdc_rise) begin
            if (bit_cnt_reg == 6'd31) begin
              bit_cnt_reg <= 6'd0;
              state_reg   <= ST_IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
          end
        end

        default: begin
          bit_cnt_reg <= 6'd0;
          MDIO_IN     <= 1'b1;
          PHY_OE      <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_phy_slave.sv
// -----------------------------------------------------------------------------
// tb_mdio_phy_slave
//
// Self-checking bench for mdio_phy_slave. The bench plays the MDIO controller:
// it drives frames bit by bit and samples MDIO_IN just before each MDC rise.
// Expected writes and expected read words go into queues when a frame is
// issued. They are popped when the DUT strobes a write or when a read frame
// completes.
// -----------------------------------------------------------------------------
module tb_mdio_phy_slave;

  logic        clk = 1'b0;
  logic        RESET;
  logic        MDC;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic        MDIO_IN;
  logic        PHY_OE;
  logic        WR_STROBE;
  logic [4:0]  WR_ADDR;
  logic [15:0] WR_DATA;
  logic        FRAME_ERR;

  mdio_phy_slave #(.PHY_ADDR(5'd1)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .MDC       (MDC),
    .MDIO_OUT  (MDIO_OUT),
    .MDIO_OE   (MDIO_OE),
    .MDIO_IN   (MDIO_IN),
    .PHY_OE    (PHY_OE),
    .WR_STROBE (WR_STROBE),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .FRAME_ERR (FRAME_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [16:0] rd_q[$];

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   err_pulses = 0;
  logic strobe_prev = 1'b0;

  // Write-strobe scoreboard and FRAME_ERR pulse counter
  always @(negedge clk) begin
    if (RESET === 1'b1) begin
      strobe_prev = 1'b0;
    end else begin
      if (FRAME_ERR === 1'b1) err_pulses++;
      if (WR_STROBE === 1'b1) begin
        n_checks++;
        if (strobe_prev !== 1'b0) begin
          n_fail++;
          $display("FAIL strobe_width: WR_STROBE high %0d consecutive cycles, required 1", 2);
        end
        n_checks++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: WR_STROBE with addr=%0d data=%h, no write expected", WR_ADDR, WR_DATA);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          if ({WR_ADDR, WR_DATA} !== {e.addr, e.data})
            begin
              n_fail++;
              $display("FAIL write_contents: addr=%0d data=%h, required addr=%0d data=%h", WR_ADDR, WR_DATA, e.addr, e.data);
            end
          else
            $display("write strobe addr=%0d data=%h", WR_ADDR, WR_DATA);
        end
      end
      strobe_prev = WR_STROBE;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller-side bit engine (all driving on negedge clk)
  // ---------------------------------------------------------------------------
  task automatic bit_cycle(input logic d, input logic oe, output logic s_in, output logic s_oe);
    MDIO_OUT = d;
    MDIO_OE  = oe;
    repeat (4) @(negedge clk);
    s_in = MDIO_IN;
    s_oe = PHY_OE;
    MDC  = 1'b1;
    repeat (4) @(negedge clk);
    MDC  = 1'b0;
  endtask

  task automatic preamble();
    logic si, so;
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b1, si, so);
  endtask

  // Sends bits 0..nbits-1 of word (bit 0 = word[31]). From bit oe_cut on the
  // controller releases the line and puts random junk on MDIO_OUT.
  task automatic send_frame(input logic [31:0] word, input int nbits, input int oe_cut,
                            output logic [16:0] got, output logic drove,
                            output logic oe_at20, output logic released);
    logic si, so;
    got = '0; drove = 1'b0; oe_at20 = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i < oe_cut) bit_cycle(word[31-i], 1'b1, si, so);
      else            bit_cycle(1'($urandom_range(0, 1)), 1'b0, si, so);
      if (i >= 15) got = {got[15:0], si};
      if (so !== 1'b0 || si !== 1'b1) drove = 1'b1;
      if (i == 20) oe_at20 = so;
    end
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b1;
    repeat (4) @(negedge clk);
    released = (PHY_OE === 1'b0) && (MDIO_IN === 1'b1);
  endtask

  function automatic logic [31:0] wr_word(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    return {2'b01, 2'b01, phy, ra, 2'b10, d};
  endfunction

  function automatic logic [31:0] rd_word(input logic [4:0] phy, input logic [4:0] ra);
    return {2'b01, 2'b10, phy, ra, 18'h0};
  endfunction

  // Read transaction: pops the expected word queued by the caller.
  task automatic read_and_check(input string name, input logic [4:0] ra);
    logic [16:0] got, exp;
    logic drove, oe20, rel;
    int e0;
    e0 = err_pulses;
    preamble();
    send_frame(rd_word(5'd1, ra), 32, 14, got, drove, oe20, rel);
    exp = rd_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_data: sampled %b, required %b", name, got, exp);
    end else
      $display("read reg %0d: sampled %b", ra, got);
    n_checks++;
    if (oe20 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_phy_oe: PHY_OE=%b mid data, required 1", name, oe20);
    end
    n_checks++;
    if (rel !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: PHY_OE=%b MDIO_IN=%b after bit 31, required 0/1", name, PHY_OE, MDIO_IN);
    end
    n_checks++;
    if (err_pulses - e0 != 0) begin
      n_fail++;
      $display("FAIL %s_frame_err: %0d pulses, required 0", name, err_pulses - e0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RESET = 1'b1; MDC = 1'b0; MDIO_OUT = 1'b1; MDIO_OE = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (MDIO_IN !== 1'b1)    begin n_fail++; $display("FAIL reset_mdio_in: %b, required 1", MDIO_IN); end
    n_checks++; if (PHY_OE !== 1'b0)     begin n_fail++; $display("FAIL reset_phy_oe: %b, required 0", PHY_OE); end
    n_checks++; if (WR_STROBE !== 1'b0)  begin n_fail++; $display("FAIL reset_wr_strobe: %b, required 0", WR_STROBE); end
    n_checks++; if (FRAME_ERR !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_err: %b, required 0", FRAME_ERR); end
    n_checks++; if (WR_ADDR !== 5'd0)    begin n_fail++; $display("FAIL reset_wr_addr: %0d, required 0", WR_ADDR); end
    n_checks++; if (WR_DATA !== 16'h0)   begin n_fail++; $display("FAIL reset_wr_data: %h, required 0000", WR_DATA); end
    $display("reset: MDIO_IN=%b PHY_OE=%b WR_ADDR=%0d WR_DATA=%h", MDIO_IN, PHY_OE, WR_ADDR, WR_DATA);
    RESET = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [16:0] got; logic drove, oe20, rel; int e0;
    e0 = err_pulses;
    wr_q.push_back('{addr: 5'd3, data: 16'hA5A5});
    preamble();
    send_frame(wr_word(5'd1, 5'd3, 16'hA5A5), 32, 32, got, drove, oe20, rel);
    n_checks++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL write_strobe: %0d writes pending, required 0", wr_q.size()); end
    n_checks++; if (drove !== 1'b0)   begin n_fail++; $display("FAIL write_no_drive: drove=%b, required 0", drove); end
    n_checks++; if (err_pulses - e0 != 0) begin n_fail++; $display("FAIL write_frame_err: %0d pulses, required 0", err_pulses - e0); end
  endtask

  task automatic test_read();
    rd_q.push_back({1'b0, 16'hA5A5});
    read_and_check("read_reg3", 5'd3);
    rd_q.push_back({1'b0, 16'h0000});
    read_and_check("read_reg7", 5'd7);
  endtask

  task automatic test_phyad_mismatch();
    logic [16:0] got; logic drove, oe20, rel; int e0;
    e0 = err_pulses;
    preamble();
    send_frame(wr_word(5'd2, 5'd3, 16'h5A5A), 32, 32, got, drove, oe20, rel);
    n_checks++; if (err_pulses - e0 != 0) begin n_fail++; $display("FAIL mismatch_wr_err: %0d pulses, required 0", err_pulses - e0); end
    n_checks++; if (drove !== 1'b0)       begin n_fail++; $display("FAIL mismatch_wr_drive: drove=%b, required 0", drove); end
    preamble();
    send_frame(rd_word(5'd2, 5'd3), 32, 14, got, drove, oe20, rel);
    n_checks++; if (drove !== 1'b0)       begin n_fail++; $display("FAIL mismatch_rd_drive: drove=%b, required 0", drove); end
    rd_q.push_back({1'b0, 16'hA5A5});
    read_and_check("mismatch_reread", 5'd3);
  endtask

  task automatic test_frame_errors();
    logic [16:0] got; logic drove, oe20, rel; int e0;
    e0 = err_pulses;
    preamble();
    send_frame(32'h3FFF_FFFF, 32, 32, got, drove, oe20, rel);   // ST=00
    n_checks++; if (err_pulses - e0 != 1) begin n_fail++; $display("FAIL st00_err: %0d pulses, required 1", err_pulses - e0); end
    n_checks++; if (drove !== 1'b0)       begin n_fail++; $display("FAIL st00_drive: drove=%b, required 0", drove); end
    e0 = err_pulses;
    preamble();
    send_frame({2'b01, 2'b11, 5'd1, 5'd3, 2'b10, 16'hFFFF}, 32, 32, got, drove, oe20, rel);
    n_checks++; if (err_pulses - e0 != 1) begin n_fail++; $display("FAIL op11_err: %0d pulses, required 1", err_pulses - e0); end
    n_checks++; if (drove !== 1'b0)       begin n_fail++; $display("FAIL op11_drive: drove=%b, required 0", drove); end
    rd_q.push_back({1'b0, 16'hA5A5});
    read_and_check("op11_reread", 5'd3);
  endtask

  task automatic test_write_abort();
    logic [16:0] got; logic drove, oe20, rel; int e0;
    e0 = err_pulses;
    preamble();
    send_frame(wr_word(5'd1, 5'd5, 16'hBEEF), 32, 20, got, drove, oe20, rel);
    n_checks++; if (err_pulses - e0 != 1) begin n_fail++; $display("FAIL abort_err: %0d pulses, required 1", err_pulses - e0); end
    rd_q.push_back({1'b0, 16'h0000});
    read_and_check("abort_reread", 5'd5);
  endtask

  task automatic test_back_to_back();
    logic [16:0] got; logic drove, oe20, rel;
    wr_q.push_back('{addr: 5'd0,  data: 16'hFFFF});
    wr_q.push_back('{addr: 5'd31, data: 16'h1234});
    preamble();
    send_frame(wr_word(5'd1, 5'd0, 16'hFFFF), 32, 32, got, drove, oe20, rel);
    send_frame(wr_word(5'd1, 5'd31, 16'h1234), 32, 32, got, drove, oe20, rel);
    n_checks++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL b2b_strobes: %0d writes pending, required 0", wr_q.size()); end
    rd_q.push_back({1'b0, 16'hFFFF});
    rd_q.push_back({1'b0, 16'h1234});
    read_and_check("b2b_reg0", 5'd0);
    read_and_check("b2b_reg31", 5'd31);
  endtask

  task automatic test_reset_mid_read();
    logic [16:0] got; logic drove, oe20, rel;
    preamble();
    send_frame(rd_word(5'd1, 5'd3), 21, 14, got, drove, oe20, rel);
    // MDC now stalled low after bit 20; the PHY must still be driving.
    n_checks++; if (PHY_OE !== 1'b1) begin n_fail++; $display("FAIL stall_phy_oe: %b, required 1", PHY_OE); end
    #2 RESET = 1'b1;
    #1;
    n_checks++; if (PHY_OE !== 1'b0)  begin n_fail++; $display("FAIL async_reset_phy_oe: %b, required 0", PHY_OE); end
    n_checks++; if (MDIO_IN !== 1'b1) begin n_fail++; $display("FAIL async_reset_mdio_in: %b, required 1", MDIO_IN); end
    $display("reset mid-read: PHY_OE=%b MDIO_IN=%b before next clk edge", PHY_OE, MDIO_IN);
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    repeat (2) @(negedge clk);
    rd_q.push_back({1'b0, 16'h0000});
    read_and_check("post_reset_reg3", 5'd3);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_phyad_mismatch();
    test_frame_errors();
    test_write_abort();
    test_back_to_back();
    test_reset_mid_read();
    repeat (4) @(negedge clk);
    n_checks++;
    if (wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_writes: %0d expected writes never strobed, required 0", wr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_phy_slave.md
MDIO_PHY_SLAVE -- requirements
Module: mdio_phy_slave

Interface
REQ-001 Parameter PHY_ADDR, default 5'd1, management address to which this block responds.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 MDC  input  1  management clock from the MDIO controller; sampled by clk.
REQ-005 MDIO_OUT  input  1  serial frame bits from the controller.
REQ-006 MDIO_OE  input  1  controller drive enable; 1 means MDIO_OUT is valid.
REQ-007 MDIO_IN  output  1  serial read data returned to the controller; idles at 1 (pull-up emulation).
REQ-008 PHY_OE  output  1  1 while this block drives MDIO_IN.
REQ-009 WR_STROBE  output  1  one-clk pulse on a completed register write.
REQ-010 WR_ADDR  output  5  register address of the last write.
REQ-011 WR_DATA  output  16  data of the last write.
REQ-012 FRAME_ERR  output  1  one-clk pulse on a malformed frame.

Function
REQ-013 MDC, MDIO_OUT and MDIO_OE SHALL each be registered twice in clk; MDC rise = stage2 0, stage1 1; MDC fall = stage2 1, stage1 0; data is sampled from stage1 on a detected rise.
REQ-014 Frame format, MSB first, bit index n = n-th MDC rise of the frame: bits 0-1 ST=01, 2-3 OP (01 write, 10 read), 4-8 PHYAD, 9-13 REGAD, 14-15 TA, 16-31 DATA[15:0].
REQ-015 Block SHALL hold a 32 x 16 register file, written only by valid write frames.
REQ-016 States: IDLE, HDR (bits 1-13), WR (bits 14-31, write), RD (bits 14-31, read), SKIP (bits 14-31, ignored frame).
REQ-017 IDLE: a rise with MDIO_OE=1 and sampled bit 0 SHALL start a frame (bit counter = 1, go HDR); a sampled 1 SHALL stay in IDLE (preamble ones are ignored).
REQ-018 HDR: bit 1 sampled 0 SHALL pulse FRAME_ERR and return to IDLE.
REQ-019 At bit 13: OP=01 with PHYAD=PHY_ADDR go WR; OP=10 with match go RD; OP of 00 or 11 pulses FRAME_ERR and goes SKIP; PHYAD mismatch goes SKIP without error.
REQ-020 RD SHALL latch reg[REGAD] at bit 13 into a 16-bit shift register.
REQ-021 WR: a rise with MDIO_OE=0 during bits 14-31 SHALL pulse FRAME_ERR, abort to IDLE, no write.
REQ-022 WR: on bit 31 rise, reg[REGAD] <= collected DATA; WR_ADDR/WR_DATA updated in that cycle; WR_STROBE high exactly the following clk cycle; go IDLE.
REQ-023 RD drive timing: on the MDC fall after bit 14 rise set PHY_OE=1, MDIO_IN=0 (TA); on the falls after bits 15..30 drive DATA[15] down to DATA[0]; on the fall after bit 31 set PHY_OE=0, MDIO_IN=1, go IDLE.
REQ-024 RD: MDIO_OUT/MDIO_OE contents SHALL be ignored after bit 13.
REQ-025 SKIP: count rises to bit 31 without driving anything, then IDLE.
REQ-026 Outside RD, PHY_OE=0 and MDIO_IN=1 at all times.
REQ-027 No timeout: a stalled MDC holds state indefinitely.

Reset
REQ-028 RESET SHALL immediately force: state IDLE, bit counter 0, MDIO_IN=1, PHY_OE=0, WR_STROBE=0, FRAME_ERR=0, WR_ADDR=0, WR_DATA=0, synchronizer stages 0, all 32 registers 0x0000.
REQ-029 RESET mid-frame SHALL discard the frame; the next frame is recognised normally after release.

Verification
REQ-030 Write frame 01_01_00001_00011_10_A5A5 -> WR_STROBE one cycle, WR_ADDR=3, WR_DATA=0xA5A5, MDIO_IN stays 1.
REQ-031 Read frame 01_10_00001_00011 after REQ-030 -> PHY_OE=1, master-sampled bits 0 then 1010010110100101, PHY_OE=0 after bit 31.
REQ-032 Read of unwritten reg 7 -> TA 0 then sixteen 0 bits; FRAME_ERR stays 0.
REQ-033 Write with PHYAD=00010 -> no WR_STROBE, no FRAME_ERR, reg 3 unchanged (re-read returns 0xA5A5).
REQ-034 Frames with ST=00 and with OP=11 -> one FRAME_ERR pulse each, no write, no drive.
REQ-035 RESET asserted at bit 20 of a read -> MDIO_IN=1, PHY_OE=0 without waiting for clk; subsequent read of reg 3 returns 0x0000.
